// File: rtl/mux_tree_pkg.sv
// Shared defaults and helpers for the pipelined mux tree.
// Used by mux_tree_pipe and mux_stage (optional scan feature: MUX_TREE_SCAN_EN).
package mux_tree_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SEL_W_DEF  = 3;

  // Number of input channels addressed by a select of sel_w bits.
  function automatic int chan_count(input int sel_w);
    return 1 << sel_w;
  endfunction

  // Word offset of tree level lvl inside a flattened heap-style layout:
  // level 0 holds all channels, each following level holds half as many words.
  function automatic int lvl_word_off(input int n_chan, input int lvl);
    return 2 * n_chan - ((2 * n_chan) >> lvl);
  endfunction

endpackage

// File: rtl/mux_tree_pipe_stage.sv
// One level of the mux tree: PAIRS 2:1 muxes sharing a select bit, followed
// by an enable-gated, asynchronously reset output register.
module mux_stage
  import mux_tree_pkg::*;
#(
  parameter int PAIRS = 1,
  parameter int W     = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sel_bit,
  input  logic [2*PAIRS*W-1:0] d_i,
  output logic [PAIRS*W-1:0]   q_o
);

  logic [PAIRS*W-1:0] q_d, q_q;

  // Pair p combines words 2p (sel_bit=0) and 2p+1 (sel_bit=1).
  always_comb begin
    q_d = '0;
    for (int p = 0; p < PAIRS; p++) begin
      q_d[p*W +: W] = sel_bit ? d_i[(2*p+1)*W +: W] : d_i[(2*p)*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q_q <= '0;
    else if (en) q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree, one register stage per select bit, one sample/cycle.
// Define MUX_TREE_SCAN_EN to add the auto-scan channel counter (scan_en/scan_clr).
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [chan_count(SEL_W)*DATA_W-1:0] in,
  input  logic [SEL_W-1:0]                  sel,
  input  logic                              valid_in,
  input  logic                              scan_en,
  input  logic                              scan_clr,
  output logic [DATA_W-1:0]                 out,
  output logic [SEL_W-1:0]                  chan_out,
  output logic                              valid_out
);

  localparam int N      = chan_count(SEL_W);
  localparam int TREE_W = (2 * N - 1) * DATA_W;

  // All tree levels live in one vector so every bit has exactly one driver.
  logic [TREE_W-1:0] tree;
  logic [SEL_W-1:0]  idx_d;
  logic [SEL_W-1:0]  idx_q [1:SEL_W];
  logic [SEL_W:1]    vld_q;

  assign tree[N*DATA_W-1:0] = in;

`ifdef MUX_TREE_SCAN_EN
  logic [SEL_W-1:0] scan_d, scan_q;

  // Clear wins over increment; the accepted sample still sees scan_q.
  always_comb begin
    scan_d = scan_q;
    if (scan_clr)                 scan_d = '0;
    else if (valid_in && scan_en) scan_d = scan_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     scan_q <= '0;
    else if (en) scan_q <= scan_d;
  end

  assign idx_d = scan_en ? scan_q : sel;
`else
  logic unused_scan;
  assign unused_scan = scan_en ^ scan_clr;
  assign idx_d       = sel;
`endif

  // Index and valid travel alongside the data; level k reads index bit k-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 1; k <= SEL_W; k++) idx_q[k] <= '0;
    end else if (en) begin
      vld_q[1] <= valid_in;
      idx_q[1] <= idx_d;
      for (int k = 2; k <= SEL_W; k++) begin
        vld_q[k] <= vld_q[k-1];
        idx_q[k] <= idx_q[k-1];
      end
    end
  end

  for (genvar k = 1; k <= SEL_W; k++) begin : g_lvl
    localparam int PAIRS   = N >> k;
    localparam int IN_OFF  = lvl_word_off(N, k - 1) * DATA_W;
    localparam int OUT_OFF = lvl_word_off(N, k) * DATA_W;

    logic sel_bit;

    if (k == 1) begin : g_first
      assign sel_bit = idx_d[0];
    end else begin : g_rest
      assign sel_bit = idx_q[k-1][k-1];
    end

    mux_stage #(
      .PAIRS (PAIRS),
      .W     (DATA_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .sel_bit (sel_bit),
      .d_i     (tree[IN_OFF +: 2*PAIRS*DATA_W]),
      .q_o     (tree[OUT_OFF +: PAIRS*DATA_W])
    );
  end

  assign out       = tree[lvl_word_off(N, SEL_W)*DATA_W +: DATA_W];
  assign chan_out  = idx_q[SEL_W];
  assign valid_out = vld_q[SEL_W];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe (DATA_W=8, SEL_W=3); scan checks when
// MUX_TREE_SCAN_EN is defined, fixed-select checks otherwise.
module tb_mux_tree_pipe;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int N      = 8;

  logic                clk = 1'b0;
  logic                rst, en, valid_in, scan_en, scan_clr;
  logic [N*DATA_W-1:0] in_v;
  logic [SEL_W-1:0]    sel;
  logic [DATA_W-1:0]   out;
  logic [SEL_W-1:0]    chan_out;
  logic                valid_out;

  int tests = 0;
  int fails = 0;

  mux_tree_pipe #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (in_v),
    .sel       (sel),
    .valid_in  (valid_in),
    .scan_en   (scan_en),
    .scan_clr  (scan_clr),
    .out       (out),
    .chan_out  (chan_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel i carries 8'hA0+i, so a valid output for channel c must be A0+c.
  task automatic chk_o(input string tag, input logic v, input logic [SEL_W-1:0] c);
    logic [DATA_W-1:0] e;
    e = 8'hA0 + {5'b0, c};
    check({tag, ".valid"}, {31'b0, valid_out}, {31'b0, v});
    if (v) begin
      check({tag, ".out"},  {24'b0, out},      {24'b0, e});
      check({tag, ".chan"}, {29'b0, chan_out}, {29'b0, c});
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; valid_in = 1'b0; scan_en = 1'b0; scan_clr = 1'b0;
    sel = '0;
    for (int i = 0; i < N; i++) in_v[i*DATA_W +: DATA_W] = 8'hA0 + i[7:0];

    // Reset state
    #12;
    check("rst.valid", {31'b0, valid_out}, 32'd0);
    check("rst.out",   {24'b0, out},       32'd0);
    check("rst.chan",  {29'b0, chan_out},  32'd0);
    step();
    rst = 1'b0;

    // Single sample, 3-cycle latency, valid for exactly one cycle
    sel = 3'd5; valid_in = 1'b1;
    step(); valid_in = 1'b0;
    chk_o("single.t1", 1'b0, 3'd0);
    step();
    chk_o("single.t2", 1'b0, 3'd0);
    step();
    chk_o("single.t3", 1'b1, 3'd5);
    step();
    chk_o("single.t4", 1'b0, 3'd0);

    // Back-to-back select sweep
    for (int i = 0; i < 8; i++) begin
      sel = i[2:0]; valid_in = 1'b1;
      step();
      if (i >= 2) chk_o("sweep", 1'b1, 3'(i - 2));
      else        chk_o("sweep.fill", 1'b0, 3'd0);
    end
    valid_in = 1'b0;
    step(); chk_o("sweep", 1'b1, 3'd6);
    step(); chk_o("sweep", 1'b1, 3'd7);
    step(); chk_o("sweep.end", 1'b0, 3'd0);

    // Stall with samples in flight
    for (int i = 1; i <= 3; i++) begin
      sel = i[2:0]; valid_in = 1'b1;
      step();
    end
    chk_o("stall.pre", 1'b1, 3'd1);
    en = 1'b0; sel = 3'd7;
    step(); chk_o("stall.hold1", 1'b1, 3'd1);
    step(); chk_o("stall.hold2", 1'b1, 3'd1);
    en = 1'b1; valid_in = 1'b0;
    step(); chk_o("stall.s2", 1'b1, 3'd2);
    step(); chk_o("stall.s3", 1'b1, 3'd3);
    step(); chk_o("stall.end", 1'b0, 3'd0);

    // Asynchronous reset mid-stream
    for (int i = 4; i <= 6; i++) begin
      sel = i[2:0]; valid_in = 1'b1;
      step();
    end
    chk_o("arst.pre", 1'b1, 3'd4);
    #2 rst = 1'b1;
    #1;
    check("arst.valid", {31'b0, valid_out}, 32'd0);
    check("arst.out",   {24'b0, out},       32'd0);
    check("arst.chan",  {29'b0, chan_out},  32'd0);
    step();
    check("arst.hold", {31'b0, valid_out}, 32'd0);
    rst = 1'b0;
    sel = 3'd3; valid_in = 1'b1;
    step(); valid_in = 1'b0;
    step(); chk_o("arst.t2", 1'b0, 3'd0);
    step(); chk_o("arst.first", 1'b1, 3'd3);

`ifdef MUX_TREE_SCAN_EN
    // Auto-scan: 0..7,0,1,... then clear while counter is 6
    begin
      logic [SEL_W-1:0] expc [16];
      for (int i = 0; i < 16; i++) expc[i] = (i < 15) ? 3'(i % 8) : 3'd0;
      sel = 3'd7;
      for (int i = 0; i < 16; i++) begin
        scan_en = 1'b1; valid_in = 1'b1; scan_clr = (i == 14);
        step();
        if (i >= 2) chk_o("scan", 1'b1, expc[i-2]);
      end
      scan_clr = 1'b0; valid_in = 1'b0;
      step(); chk_o("scan.clr6", 1'b1, expc[14]);
      step(); chk_o("scan.after", 1'b1, expc[15]);
      step(); chk_o("scan.end", 1'b0, 3'd0);
      scan_en = 1'b0;
    end
`else
    // scan_en is ignored without the scan feature
    scan_en = 1'b1; sel = 3'd2; valid_in = 1'b1;
    step(); valid_in = 1'b0;
    step();
    step(); chk_o("noscan", 1'b1, 3'd2);
    scan_en = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
